// File: rtl/jtframe_prog_stream_pkg.sv
// jtframe_prog_stream_pkg: shared FSM encodings and byte-lane mask constants
package jtframe_prog_stream_pkg;
  typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;
  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;
endpackage

// File: rtl/jtframe_prog_stream_fifo.sv
// jtframe_prog_stream_fifo: synchronous FIFO with full/empty flags and registered count
module jtframe_prog_stream_fifo #(
  parameter int W  = 32,
  parameter int AW = 2
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]  mem [0:2**AW-1];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  assign full  = cnt == (AW+1)'(2**AW);
  assign empty = cnt == '0;
  assign dout  = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(push);
      rp  <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/jtframe_prog_stream.sv
// jtframe_prog_stream: strips the ioctl header, buffers bytes and replays them as paced
// 16-bit-word prog writes with active-low byte masks
module jtframe_prog_stream
  import jtframe_prog_stream_pkg::*;
#(
  parameter int PW     = 24,
  parameter int HEADER = 0,
  parameter int SWAB   = 0,
  parameter int FAW    = 2,
  parameter int GAP    = 2
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [PW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  output logic          ioctl_wait,
  output logic [PW-1:0] prog_addr,
  output logic [1:0]    prog_mask,
  output logic [7:0]    prog_data,
  output logic          prog_we,
  output logic          done,
  output logic          overflow
);
  logic [PW-1:0] eff, q_addr;
  logic [7:0]    q_data;
  logic          full, empty, hit, push, pop, lane, dl_l, armed, dl_rise;
  logic [3:0]    gap_cnt;
  state_t        st;
  assign hit        = ioctl_wr && downloading && ioctl_addr >= PW'(HEADER);
  assign push       = hit && !full;
  assign pop        = st == IDLE && !empty;
  assign eff        = ioctl_addr - PW'(HEADER);
  assign lane       = q_addr[0] ^ (SWAB != 0);
  assign dl_rise    = downloading && !dl_l;
  assign ioctl_wait = full;
  jtframe_prog_stream_fifo #(.W(PW+8), .AW(FAW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({eff, ioctl_dout}),
    .dout  ({q_addr, q_data}),
    .full  (full),
    .empty (empty)
  );
  // armed keeps done low after reset until a download has actually happened
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st        <= IDLE;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_we   <= 1'b0;
      gap_cnt   <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      dl_l      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      dl_l     <= downloading;
      armed    <= armed | downloading;
      done     <= dl_rise ? 1'b0 : done | (armed && !downloading && empty && st == IDLE);
      overflow <= (overflow && !dl_rise) || (hit && full);
      case (st)
        IDLE:
          if (!empty) begin
            prog_addr <= {1'b0, q_addr[PW-1:1]};
            prog_mask <= lane ? MASK_HI : MASK_LO;
            prog_data <= q_data;
            prog_we   <= 1'b1;
            st        <= STROBE;
          end
        STROBE: begin
          prog_we <= 1'b0;
          gap_cnt <= 4'(GAP - 1);
          st      <= GAP == 0 ? IDLE : HOLD;
        end
        HOLD: begin
          gap_cnt <= gap_cnt - 4'd1;
          st      <= gap_cnt == 4'd0 ? IDLE : HOLD;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_jtframe_prog_stream.sv
// tb_jtframe_prog_stream: scoreboard bench for two configurations of jtframe_prog_stream
module tb_jtframe_prog_stream;
  logic        clk = 0, rst_n = 0;
  logic        a_dl = 0, a_wr = 0, a_wait, a_we, a_done, a_ovf;
  logic [23:0] a_addr = 0, a_paddr;
  logic [7:0]  a_dout = 0, a_pdata;
  logic [1:0]  a_mask;
  logic        b_dl = 0, b_wr = 0, b_wait, b_we, b_done, b_ovf;
  logic [23:0] b_addr = 0, b_paddr;
  logic [7:0]  b_dout = 0, b_pdata;
  logic [1:0]  b_mask;
  logic [33:0] qa[$], qb[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int a_gap = 0, b_gap = 0, a_last = -1, b_last = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtframe_prog_stream #(.PW(24), .HEADER(4), .SWAB(0), .FAW(2), .GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .downloading(a_dl), .ioctl_addr(a_addr), .ioctl_dout(a_dout),
    .ioctl_wr(a_wr), .ioctl_wait(a_wait), .prog_addr(a_paddr), .prog_mask(a_mask),
    .prog_data(a_pdata), .prog_we(a_we), .done(a_done), .overflow(a_ovf));

  jtframe_prog_stream #(.PW(24), .HEADER(0), .SWAB(1), .FAW(2), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .downloading(b_dl), .ioctl_addr(b_addr), .ioctl_dout(b_dout),
    .ioctl_wr(b_wr), .ioctl_wait(b_wait), .prog_addr(b_paddr), .prog_mask(b_mask),
    .prog_data(b_pdata), .prog_we(b_we), .done(b_done), .overflow(b_ovf));

  task automatic check(string tag, logic [39:0] obs, logic [39:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] model(int a, logic [7:0] d, int hdr, bit swab);
    int eff = a - hdr;
    logic [1:0] m = (eff[0] ^ swab) ? 2'b01 : 2'b10;
    return {24'(eff >> 1), m, d};
  endfunction

  // scoreboard: every prog_we pulse pops one expected word
  always @(negedge clk) begin
    if (a_we) begin
      if (qa.size() == 0) check("a_unexpected_we", 1, 0);
      else check("a_word", {a_paddr, a_mask, a_pdata}, qa.pop_front());
      if (a_gap != 0 && a_last >= 0) check("a_spacing", cyc - a_last, a_gap);
      a_last = cyc;
    end
    if (b_we) begin
      if (qb.size() == 0) check("b_unexpected_we", 1, 0);
      else check("b_word", {b_paddr, b_mask, b_pdata}, qb.pop_front());
      if (b_gap != 0 && b_last >= 0) check("b_spacing", cyc - b_last, b_gap);
      b_last = cyc;
    end
  end

  task automatic a_byte(int addr, logic [7:0] d, bit acc);
    @(negedge clk);
    a_addr = 24'(addr); a_dout = d; a_wr = 1;
    if (acc) qa.push_back(model(addr, d, 4, 0));
  endtask

  task automatic drain(bit is_b);
    for (int i = 0; i < 200 && (is_b ? qb.size() : qa.size()) != 0; i++) @(negedge clk);
    check(is_b ? "b_drain" : "a_drain", is_b ? qb.size() : qa.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_mask", a_mask, 2'b11);
    check("rst_we", a_we, 0);
    check("rst_wait", a_wait, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("idle_done", a_done, 0);
    check("idle_addr_data", {a_paddr, a_pdata}, 0);
    check("idle_ovf", a_ovf, 0);
    // header strip and lane selection
    a_dl = 1;
    for (int i = 0; i < 8; i++) a_byte(i, 8'(i), i >= 4);
    @(negedge clk); a_wr = 0;
    drain(0);
    check("t1_ovf", a_ovf, 0);
    // byte swap on the second instance
    b_dl = 1;
    @(negedge clk); b_addr = 24'h10; b_dout = 8'hA5; b_wr = 1;
    qb.push_back({24'h8, 2'b01, 8'hA5});
    @(negedge clk); b_wr = 0;
    drain(1);
    // overflow: wr held 8 cycles; bytes 5 and 7 hit a full FIFO
    a_gap = 4; a_last = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("t3_wait%0d", i), a_wait, (i == 5 || i == 7));
      a_addr = 24'(8 + i); a_dout = 8'(8'h10 + i); a_wr = 1;
      if (i != 5 && i != 7) qa.push_back(model(8 + i, 8'(8'h10 + i), 4, 0));
    end
    @(negedge clk); a_wr = 0;
    check("t3_ovf", a_ovf, 1);
    drain(0);
    check("t3_wait_end", a_wait, 0);
    // download ends with 3 entries queued
    a_last = -1;
    for (int i = 0; i < 4; i++) a_byte(16 + i, 8'(8'h40 + i), 1);
    @(negedge clk); a_wr = 0; a_dl = 0;
    check("t4_done_early", a_done, 0);
    for (int i = 0; i < 100 && !a_done; i++) @(negedge clk);
    check("t4_done", a_done, 1);
    check("t4_done_latency", cyc - a_last, 4);
    check("t4_queue", qa.size(), 0);
    check("t4_ovf_kept", a_ovf, 1);
    repeat (3) @(negedge clk);
    check("t4_done_sticky", a_done, 1);
    a_dl = 1;
    @(negedge clk);
    check("t4_done_clr", a_done, 0);
    check("t4_ovf_clr", a_ovf, 0);
    a_gap = 0;
    // GAP=0 stream honouring ioctl_wait
    begin
      int n = 0, g = 0;
      b_gap = 2; b_last = -1;
      while (n < 10 && g < 200) begin
        @(negedge clk); g++;
        if (b_wait) b_wr = 0;
        else begin
          b_addr = 24'(8'h20 + n); b_dout = 8'(8'h30 + n); b_wr = 1;
          qb.push_back(model(8'h20 + n, 8'(8'h30 + n), 0, 1));
          n++;
        end
      end
      @(negedge clk); b_wr = 0;
      check("t6_sent", n, 10);
    end
    drain(1);
    check("t6_ovf", b_ovf, 0);
    b_gap = 0;
    // reset mid-drain with 2 entries queued
    a_byte(24, 8'h55, 1);
    a_byte(25, 8'h66, 0);
    a_byte(26, 8'h77, 0);
    @(negedge clk); a_wr = 0; rst_n = 0;
    #1;
    check("t5_addr", a_paddr, 0);
    check("t5_data", a_pdata, 0);
    check("t5_mask", a_mask, 2'b11);
    check("t5_we", a_we, 0);
    check("t5_flags", {a_done, a_ovf, a_wait}, 0);
    check("t5_b_mask", b_mask, 2'b11);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    check("t5_queue", qa.size(), 0);
    check("end_b_queue", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
